// File: rtl/traffic_phase_controller.sv
// Phase sequencer for a two-road intersection with a pedestrian crossing.
// Phase durations are counted in divider ticks; side-road and pedestrian requests are latched.
module traffic_phase_controller #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 5,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ew_sensor,
    input  logic             ped_req,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             walk,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [2:0] NS_G = 3'd0;
    localparam logic [2:0] NS_Y = 3'd1;
    localparam logic [2:0] RED1 = 3'd2;
    localparam logic [2:0] EW_G = 3'd3;
    localparam logic [2:0] EW_Y = 3'd4;
    localparam logic [2:0] RED2 = 3'd5;
    localparam logic [2:0] WALK = 3'd6;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ew_pend_q, ew_pend_d;
    logic             ped_pend_q, ped_pend_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (state_q == 3'd7) begin
            state_d = NS_G;
            timer_d = GREEN_LD;
        end else if (tick) begin
            if (timer_q != '0) begin
                timer_d = timer_q - TIMER_ONE;
            end else begin
                case (state_q)
                    NS_G:    state_d = (ew_pend_q || ped_pend_q) ? NS_Y : NS_G;
                    NS_Y:    state_d = RED1;
                    RED1:    state_d = ew_pend_q ? EW_G : (ped_pend_q ? WALK : NS_G);
                    EW_G:    state_d = EW_Y;
                    EW_Y:    state_d = RED2;
                    RED2:    state_d = ped_pend_q ? WALK : NS_G;
                    default: state_d = NS_G;
                endcase
                // Every expiry reloads, including the NS_G dwell back into itself.
                case (state_d)
                    NS_Y, EW_Y:  timer_d = YELLOW_LD;
                    RED1, RED2:  timer_d = ALLRED_LD;
                    WALK:        timer_d = WALK_LD;
                    default:     timer_d = GREEN_LD;
                endcase
            end
        end
    end

    // Clearing on entry wins over a same-cycle request: the entering phase serves it.
    always_comb begin
        ew_pend_d  = ew_pend_q;
        ped_pend_d = ped_pend_q;
        if (state_d == EW_G && state_q != EW_G) begin
            ew_pend_d = 1'b0;
        end else if (ew_sensor && state_q != EW_G) begin
            ew_pend_d = 1'b1;
        end
        if (state_d == WALK && state_q != WALK) begin
            ped_pend_d = 1'b0;
        end else if (ped_req && state_q != WALK) begin
            ped_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NS_G;
            timer_q    <= GREEN_LD;
            ew_pend_q  <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ew_pend_q  <= ew_pend_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        ns_light = 3'b100;
        ew_light = 3'b100;
        walk     = 1'b0;
        case (state_q)
            NS_G:    ns_light = 3'b001;
            NS_Y:    ns_light = 3'b010;
            EW_G:    ew_light = 3'b001;
            EW_Y:    ew_light = 3'b010;
            WALK:    walk     = 1'b1;
            default: ;
        endcase
    end

    assign phase     = state_q;
    assign remaining = timer_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Randomized and directed bench for traffic_phase_controller: a tick-level reference model feeds a
// per-cycle scoreboard, and a phase tracker records (phase, ticks spent) for directed sequence checks.
module tb_traffic_phase_controller;
  localparam int G  = 8;
  localparam int Y  = 3;
  localparam int AR = 1;
  localparam int W  = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          ew_sensor = 1'b0;
  logic          ped_req = 1'b0;
  logic [2:0]    ns_light;
  logic [2:0]    ew_light;
  logic          walk;
  logic [2:0]    phase;
  logic [CW-1:0] remaining;

  always #5 clk = ~clk;

  traffic_phase_controller #(
    .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(AR), .WALK_TICKS(W), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ew_sensor(ew_sensor), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .phase(phase), .remaining(remaining)
  );

  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];
  int seq_ph[$];
  int seq_tk[$];
  int tick_mode = 0;
  int cyc = 0;
  bit tick_at_edge = 1'b0;

  // ---------------- reference model (phase name, ticks elapsed, pending flags) ----------------
  int m_phase = 0;
  int m_el = 0;
  bit m_ew = 1'b0;
  bit m_ped = 1'b0;

  function automatic int dur(input int p);
    case (p)
      0, 3: return G;
      1, 4: return Y;
      2, 5: return AR;
      6: return W;
      default: return G;
    endcase
  endfunction

  function automatic int next_phase(input int p, input bit e, input bit d);
    case (p)
      0: return (e || d) ? 1 : 0;
      1: return 2;
      2: return e ? 3 : (d ? 6 : 0);
      3: return 4;
      4: return 5;
      5: return d ? 6 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [17:0] pack(input int p, input int rem);
    logic [2:0] pp;
    logic [7:0] rr;
    logic [2:0] ns;
    logic [2:0] ew;
    pp = 3'(p);
    rr = 8'(rem);
    ns = (p == 0) ? 3'b001 : ((p == 1) ? 3'b010 : 3'b100);
    ew = (p == 3) ? 3'b001 : ((p == 4) ? 3'b010 : 3'b100);
    return {pp, rr, ns, ew, (p == 6)};
  endfunction

  initial begin
    int np;
    bit tr;
    bit ne;
    bit nd;
    forever begin
      @(posedge clk);
      tick_at_edge = tick && !rst;
      if (rst) begin
        m_phase = 0; m_el = 0; m_ew = 1'b0; m_ped = 1'b0;
      end else begin
        tr = 1'b0;
        np = m_phase;
        if (tick) begin
          m_el++;
          if (m_el == dur(m_phase)) begin
            np = next_phase(m_phase, m_ew, m_ped);
            m_el = 0;
            tr = 1'b1;
          end
        end
        ne = (tr && np == 3) ? 1'b0 : ((m_phase != 3 && ew_sensor) ? 1'b1 : m_ew);
        nd = (tr && np == 6) ? 1'b0 : ((m_phase != 6 && ped_req) ? 1'b1 : m_ped);
        m_phase = np;
        m_ew = ne;
        m_ped = nd;
        exp_q.push_back(pack(m_phase, dur(m_phase) - 1 - m_el));
      end
    end
  end

  // ---------------- tick driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      case (tick_mode)
        1: tick = (cyc % 10 == 0);
        2: tick = ($urandom_range(0, 3) == 0);
        default: tick = 1'b0;
      endcase
    end
  end

  // ---------------- monitor: scoreboard, invariants, phase tracker ----------------
  initial begin
    int last_ph;
    int cur_ticks;
    logic [17:0] e;
    logic [17:0] got;
    last_ph = 0;
    cur_ticks = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        last_ph = 0;
        cur_ticks = 0;
      end else begin
        if (tick_at_edge) cur_ticks++;
        if (int'(phase) != last_ph) begin
          seq_ph.push_back(last_ph);
          seq_tk.push_back(cur_ticks);
          cur_ticks = 0;
          last_ph = int'(phase);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          got = {phase, remaining, ns_light, ew_light, walk};
          checks++;
          if (got !== e) begin
            failures++;
            $display("FAIL scoreboard t=%0t got ph=%0d rem=%0d ns=%b ew=%b walk=%b required ph=%0d rem=%0d ns=%b ew=%b walk=%b",
                     $time, got[17:15], got[14:7], got[6:4], got[3:1], got[0],
                     e[17:15], e[14:7], e[6:4], e[3:1], e[0]);
          end
        end
        checks++;
        if (ns_light != 3'b100 && ew_light != 3'b100) begin
          failures++;
          $display("FAIL both_roads_open t=%0t ns=%b ew=%b required one red", $time, ns_light, ew_light);
        end
        checks++;
        if (walk && (ns_light != 3'b100 || ew_light != 3'b100)) begin
          failures++;
          $display("FAIL walk_conflict t=%0t ns=%b ew=%b walk=%b", $time, ns_light, ew_light, walk);
        end
      end
    end
  end

  // ---------------- driver / directed tasks ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_ns"}, int'(ns_light), 1);
    check({name, "_ew"}, int'(ew_light), 4);
    check({name, "_walk"}, int'(walk), 0);
    check({name, "_phase"}, int'(phase), 0);
    check({name, "_rem"}, int'(remaining), G - 1);
  endtask

  task automatic wait_seq(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (seq_ph.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, (seq_ph.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_phase(input string name, input int p, input int budget);
    int k;
    k = 0;
    while (int'(phase) != p && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, int'(phase), p);
  endtask

  task automatic check_seq(input string name, input int idx, input int n, input int ph[6], input int tk[6]);
    for (int i = 0; i < n; i++) begin
      if (idx + i < seq_ph.size()) begin
        check($sformatf("%s_ph%0d", name, i), seq_ph[idx + i], ph[i]);
        check($sformatf("%s_tk%0d", name, i), seq_tk[idx + i], tk[i]);
      end else begin
        check($sformatf("%s_missing%0d", name, i), -1, ph[i]);
      end
    end
  endtask

  task automatic check_dwell(input string name);
    int idx;
    idx = seq_ph.size();
    repeat (250) @(negedge clk);
    check({name, "_no_change"}, seq_ph.size() - idx, 0);
    check({name, "_phase"}, int'(phase), 0);
  endtask

  task automatic pulse(input bit e, input bit d);
    @(negedge clk);
    ew_sensor = e;
    ped_req = d;
    @(negedge clk);
    ew_sensor = 1'b0;
    ped_req = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int idx;
    int k;
    bit saw_walk;

    repeat (3) @(negedge clk);
    check_reset("rst_initial");
    rst = 1'b0;
    tick_mode = 1;
    repeat (200) @(negedge clk);
    check("idle_no_change", seq_ph.size(), 0);
    check("idle_phase", int'(phase), 0);

    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst_mid");
    repeat (2) @(negedge clk);
    check_reset("rst_held");
    rst = 1'b0;
    repeat (30) @(negedge clk);

    idx = seq_ph.size();
    pulse(1'b1, 1'b0);
    wait_seq("ew_only", idx + 6, 600);
    check_seq("ew_only", idx + 1, 5, '{1, 2, 3, 4, 5, 0}, '{Y, AR, G, Y, AR, 0});
    check("ew_only_back", int'(phase), 0);

    idx = seq_ph.size();
    pulse(1'b0, 1'b1);
    wait_seq("ped_only", idx + 4, 600);
    check_seq("ped_only", idx + 1, 3, '{1, 2, 6, 0, 0, 0}, '{Y, AR, W, 0, 0, 0});

    idx = seq_ph.size();
    pulse(1'b1, 1'b1);
    wait_seq("both", idx + 7, 800);
    check_seq("both", idx + 1, 6, '{1, 2, 3, 4, 5, 6}, '{Y, AR, G, Y, AR, W});
    check_dwell("both_cleared");

    idx = seq_ph.size();
    saw_walk = 1'b0;
    @(negedge clk);
    ew_sensor = 1'b1;
    ped_req = 1'b1;
    k = 0;
    while (k < 800) begin
      @(negedge clk);
      k++;
      if (phase == 3'd4) ew_sensor = 1'b0;
      if (phase == 3'd6) saw_walk = 1'b1;
      if (saw_walk && phase == 3'd0) break;
    end
    ew_sensor = 1'b0;
    ped_req = 1'b0;
    check("held_reached_walk", int'(saw_walk), 1);
    wait_seq("held", idx + 7, 100);
    check_seq("held", idx + 1, 6, '{1, 2, 3, 4, 5, 6}, '{Y, AR, G, Y, AR, W});
    check_dwell("held_no_relatch");

    pulse(1'b1, 1'b0);
    wait_phase("freeze_reach", 4, 600);
    tick_mode = 0;
    repeat (1000) @(negedge clk);
    check("freeze_phase", int'(phase), 4);
    check("freeze_rem", int'(remaining), Y - 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_ns", int'(ns_light), 1);
    check("async_rst_ew", int'(ew_light), 4);
    check("async_rst_rem", int'(remaining), G - 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    tick_mode = 2;
    repeat (3000) begin
      @(negedge clk);
      ew_sensor = ($urandom_range(0, 99) < 3);
      ped_req = ($urandom_range(0, 99) < 2);
    end
    ew_sensor = 1'b0;
    ped_req = 1'b0;
    tick_mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
